// File: rtl/motor_param_regbank.sv
// motor_param_regbank: Avalon-MM bank of N-channel shadow/active motor parameters with atomic commit, status words from the comms engine (status_*), ID/pending/readback registers; define MOTOR_PARAM_WRITE_CLAMP_EN to clamp PWMLimit/IntegralLimit writes
module motor_param_regbank #(
  parameter int          NUMBER_OF_MOTORS = 6,
  parameter logic [31:0] PWM_MAX          = 32'd1000,
  parameter logic [31:0] ID_WORD          = 32'hB15B0002,
  parameter bit          AUTO_COMMIT      = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [15:0]                     address,
  input  logic                            write,
  input  logic [31:0]                     writedata,
  input  logic                            read,
  output logic [31:0]                     readdata,
  output logic                            waitrequest,
  input  logic                            update_tick,
  input  logic                            status_wr,
  input  logic [7:0]                      status_motor,
  input  logic [3:0]                      status_sel,
  input  logic [31:0]                     status_data,
  output logic [32*NUMBER_OF_MOTORS-1:0]  kp_o,
  output logic [32*NUMBER_OF_MOTORS-1:0]  ki_o,
  output logic [32*NUMBER_OF_MOTORS-1:0]  kd_o,
  output logic [32*NUMBER_OF_MOTORS-1:0]  sp_o,
  output logic [32*NUMBER_OF_MOTORS-1:0]  pwm_limit_o,
  output logic [32*NUMBER_OF_MOTORS-1:0]  int_limit_o,
  output logic [32*NUMBER_OF_MOTORS-1:0]  deadband_o,
  output logic [8*NUMBER_OF_MOTORS-1:0]   control_mode_o,
  output logic [NUMBER_OF_MOTORS-1:0]     commit_pulse_o
);
  localparam int N = NUMBER_OF_MOTORS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [31:0] RST_VAL [7] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd127, 32'd50, 32'd0};
`ifdef MOTOR_PARAM_WRITE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  logic [31:0] shadow [N][7];
  logic [31:0] active [N][7];
  logic [7:0]  mode_s [N];
  logic [7:0]  mode_a [N];
  logic [31:0] status [N][10];
  logic [N-1:0] pending, applied, wr_set;
  logic [31:0] rd_mux, wval, pend32;
  logic [7:0] rsel;
  logic [IW-1:0] idx;
  logic [2:0] p;
  logic in_range, shadow_wr, rd_ready;
  assign rsel = address[15:8];
  assign idx = address[IW-1:0];
  assign p = rsel[2:0] - 3'd1;
  assign in_range = 32'(address[7:0]) < N;
  assign shadow_wr = write && in_range && rsel >= 8'h01 && rsel <= 8'h08;
  assign waitrequest = reset || (read && !rd_ready);
  assign wval = CLAMP && (rsel == 8'h05 || rsel == 8'h06) && writedata[31] ? '0 :
                CLAMP && rsel == 8'h05 && writedata > PWM_MAX ? PWM_MAX : writedata;
  always_comb begin
    applied = '0;
    wr_set = '0;
    pend32 = '0;
    for (int i = 0; i < N; i++) begin
      applied[i] = (write && rsel == 8'h20 && i < 32 && writedata[i[4:0]]) ||
                   (AUTO_COMMIT && update_tick && pending[i]);
      wr_set[i] = shadow_wr && 32'(idx) == i;
      if (i < 32) pend32[i[4:0]] = pending[i];
    end
  end
  always_comb begin
    rd_mux = 32'hDEADBEEF;
    if (rsel == 8'h00) rd_mux = ID_WORD;
    else if (rsel == 8'h21) rd_mux = pend32;
    else if (in_range && rsel >= 8'h01 && rsel <= 8'h07) rd_mux = shadow[idx][p];
    else if (in_range && rsel == 8'h08) rd_mux = {24'd0, mode_s[idx]};
    else if (in_range && rsel >= 8'h10 && rsel <= 8'h19) rd_mux = status[idx][rsel[3:0]];
    else if (in_range && rsel == 8'h22) rd_mux = active[idx][0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ready <= 1'b0;
      readdata <= '0;
      pending <= '0;
      commit_pulse_o <= '0;
      for (int i = 0; i < N; i++) begin
        shadow[i] <= RST_VAL;
        active[i] <= RST_VAL;
        mode_s[i] <= '0;
        mode_a[i] <= '0;
        for (int s = 0; s < 10; s++) status[i][s] <= '0;
      end
    end else begin
      rd_ready <= read && !rd_ready;
      if (read && !rd_ready) readdata <= rd_mux;
      pending <= (pending & ~applied) | wr_set;
      commit_pulse_o <= applied;
      if (shadow_wr && rsel == 8'h08) mode_s[idx] <= writedata[7:0];
      else if (shadow_wr) shadow[idx][p] <= wval;
      for (int i = 0; i < N; i++)
        if (applied[i]) begin
          active[i] <= shadow[i];
          mode_a[i] <= mode_s[i];
        end
      if (status_wr && 32'(status_motor) < N && status_sel <= 4'd9)
        status[status_motor[IW-1:0]][status_sel] <= status_data;
    end
  end
  for (genvar g = 0; g < N; g++) begin : g_out
    assign kp_o[32*g +: 32] = active[g][0];
    assign ki_o[32*g +: 32] = active[g][1];
    assign kd_o[32*g +: 32] = active[g][2];
    assign sp_o[32*g +: 32] = active[g][3];
    assign pwm_limit_o[32*g +: 32] = active[g][4];
    assign int_limit_o[32*g +: 32] = active[g][5];
    assign deadband_o[32*g +: 32] = active[g][6];
    assign control_mode_o[8*g +: 8] = mode_a[g];
  end
endmodule

// File: doc/motor_param_regbank.md
Name: motor_param_regbank

Overview:
Avalon-MM slave holding per-motor control parameters and status words for N motor channels. It sits between the HPS bridge and the serial motor-communication engine.
Host parameter writes land in shadow registers and reach the active outputs only on an atomic commit, so the comms engine never sees a half-updated PID set.
Status words are written in by the comms engine through a dedicated port and read back by the host.

Parameters:
NUMBER_OF_MOTORS, 6, channel count (1..255)
PWM_MAX, 32'd1000, upper bound for PWM limit writes (used with clamp feature)
ID_WORD, 32'hB15B0002, value returned at addr 0x00
AUTO_COMMIT, 1, 1 = update_tick also commits all pending channels

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
address  in  16  [15:8] register select, [7:0] motor index
write  in  1  Avalon write
writedata  in  32  write data
read  in  1  Avalon read
readdata  out  32  read data
waitrequest  out  1  Avalon waitrequest
update_tick  in  1  1-cycle strobe from comms scheduler
status_wr  in  1  status write strobe from comms engine
status_motor  in  8  status target channel
status_sel  in  4  status word select (0..9)
status_data  in  32  status value
kp_o, ki_o, kd_o, sp_o, pwm_limit_o, int_limit_o, deadband_o  out  32*NUMBER_OF_MOTORS  active parameters, channel i at [32i+31:32i]
control_mode_o  out  8*NUMBER_OF_MOTORS  active control mode
commit_pulse_o  out  NUMBER_OF_MOTORS  1-cycle pulse per channel committed

Behaviour:
- Register map (addr byte):
  - 00 ID_WORD (RO)
  - 01..07 shadow Kp, Ki, Kd, sp, PWMLimit, IntegralLimit, deadband (RW)
  - 08 shadow control_mode (RW, bits [7:0], reads zero-extended)
  - 10..19 status words sel 0..9 (RO): enc0 pos, enc1 pos, enc0 vel, enc1 vel, current ph1..ph3, error_code, crc, comm quality
  - 20 commit mask (WO): bit i commits channel i
  - 21 pending mask (RO)
  - 22 active-readback of Kp (RO)
  - anything else reads 32'hDEADBEEF.
- Index rules:
  - Motor index >= NUMBER_OF_MOTORS: reads return 32'hDEADBEEF, writes ignored.
  - Motor index ignored for addr 00, 20, 21.
- Reset values (shadow and active alike):
  - Kp=1; Ki=Kd=sp=deadband=0; PWMLimit=127; IntegralLimit=50; control_mode=0
  - status=0; pending=0
  - readdata=0; waitrequest=1 while reset asserted; commit_pulse_o=0.
- Read handshake:
  - Cycle of read assertion: waitrequest=1, readdata registered.
  - Next cycle: waitrequest=0, read completes.
  - Back-to-back reads each take 2 cycles.
  - waitrequest = read && !rd_ready, where rd_ready is set after the first cycle and cleared when the read completes.
- Writes: zero wait states (waitrequest=0 when read=0), taken on the same edge.
- Shadow write to channel i sets pending[i].
- Commit:
  - Applied set = (write to 20 ? writedata mask : 0) | (AUTO_COMMIT && update_tick ? pending : 0), masked to existing channels.
  - For each channel in the applied set: shadow→active copy on one edge, pending[i] cleared, commit_pulse_o[i]=1 for exactly that cycle.
  - Committing a channel that is not pending is legal: it copies and pulses anyway.
- Simultaneous shadow write to channel i and update_tick:
  - The commit uses the pre-write shadow.
  - pending[i] remains set (the write wins the pending bit).
- Status port: status_wr writes status_data into [status_motor][status_sel] on the edge. Out-of-range motor or sel>9 is ignored. Independent of Avalon activity.
- Same-cycle host read of a status word being written returns the old value.
- Reset mid-read: waitrequest returns to 1 immediately; the read is abandoned.

Optional Feature:
- Macro: MOTOR_PARAM_WRITE_CLAMP_EN
- Defined:
  - PWMLimit writes clamped to [0, PWM_MAX].
  - IntegralLimit writes below 0 stored as 0.
  - Readback returns the clamped value.
- Undefined: values stored verbatim.

Test Plan:
- Reset, read addr 0x0000 → waitrequest 1 for one cycle, then readdata=32'hB15B0002.
- Write Kp ch2 (0x0102)=500 → shadow reads 500; kp_o ch2 stays 1; pending=0x04. Write 0x2000=0x04 → kp_o ch2=500 next edge, commit_pulse_o=0x04 for one cycle, pending=0.
- AUTO_COMMIT=1: write sp ch0=-1000 and ch5=42, pulse update_tick → both active, commit_pulse_o=0x21. Shadow write to ch1 in the same cycle as update_tick → ch1 active unchanged, pending bit 1 remains set.
- status_wr motor=3 sel=7 data=0xA5 → read 0x1703 returns 0xA5. Read 0x0106 (motor 6 ≥ N) → 0xDEADBEEF; write 0x0106 leaves all state unchanged.
- With MOTOR_PARAM_WRITE_CLAMP_EN: write PWMLimit ch0=5000 → reads 1000; write -3 → reads 0. Without the macro → reads 5000 and -3.
- Assert reset during the waitrequest cycle of a read → waitrequest=1 and all registers back to reset values. After release, a read of 0x0100 returns 1.
